// File: rtl/otp_pkg.sv
// otp_pkg: shared sizes and word type for the one-time-pad cryptor
package otp_pkg;
    localparam int KEY_SIZE = 16;
    localparam int MSG_SIZE = 240;
    localparam int WORDS_PER_MSG = MSG_SIZE / KEY_SIZE;
    typedef logic [KEY_SIZE-1:0] otp_word_t;
endpackage

// File: rtl/otp_xor_lane.sv
// otp_xor_lane: combinational bitwise XOR of one word
module otp_xor_lane #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);
    assign y = a ^ b;
endmodule

// File: rtl/otp_cryptor.sv
// otp_cryptor: registered one-time-pad XOR stage, one word per clock
module otp_cryptor
    import otp_pkg::*;
#(
    parameter int KEY_SIZE = otp_pkg::KEY_SIZE,
    parameter int MSG_SIZE = otp_pkg::MSG_SIZE
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [KEY_SIZE-1:0] msg,
    input  logic [KEY_SIZE-1:0] key,
    output logic [KEY_SIZE-1:0] out
);
    logic [KEY_SIZE-1:0] mix;
    // Message length is never counted; it only has to split into whole words.
    if (MSG_SIZE % KEY_SIZE != 0) begin : g_bad_size
        $error("MSG_SIZE must be a multiple of KEY_SIZE");
    end
    otp_xor_lane #(.W(KEY_SIZE)) lane (
        .a(msg),
        .b(key),
        .y(mix)
    );
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) out <= '0;
        else        out <= mix;
endmodule

// File: tb/tb_otp_cryptor.sv
// tb_otp_cryptor: directed and random checks of otp_cryptor against an XOR reference
module tb_otp_cryptor;
    import otp_pkg::*;
    logic      clk;
    logic      rst_n;
    otp_word_t msg;
    otp_word_t key;
    otp_word_t out;
    int        total;
    int        passed;
    otp_word_t msgs[$];
    otp_word_t keys[$];
    otp_word_t ciph[$];

    otp_cryptor cryptor (
        .clk(clk),
        .rst_n(rst_n),
        .msg(msg),
        .key(key),
        .out(out)
    );

    // Reference: a bit is set exactly when msg and key disagree there.
    function automatic otp_word_t ref_otp(input otp_word_t m, input otp_word_t k);
        return (m | k) & ~(m & k);
    endfunction

    task automatic tick();
        #5 clk = 1'b1;
        #5 clk = 1'b0;
    endtask

    task automatic check(input string tag, input otp_word_t exp);
        total++;
        assert (out === exp) passed++;
        else $error("FAIL %s: out=%h expected=%h", tag, out, exp);
    endtask

    initial begin
        clk = 1'b0;
        rst_n = 1'b0;
        msg = '0;
        key = '0;
        total = 0;
        passed = 0;
        #1 check("reset_async", 16'h0000);
        msg = 16'h1234;
        key = 16'h00F0;
        tick();
        check("reset_hold", 16'h0000);
        rst_n = 1'b1;
        #3 check("release_no_edge", 16'h0000);
        msg = 16'h0000; key = 16'hFFFF; tick(); check("zero_xor_ones", 16'hFFFF);
        msg = 16'hFFFF; tick(); check("ones_xor_ones", 16'h0000);
        msg = 16'hAAAA; key = 16'h5555; tick(); check("aaaa_xor_5555", 16'hFFFF);
        msg = 16'h5555; tick(); check("5555_xor_5555", 16'h0000);
        msg = 16'hFFFF; tick(); check("encrypt_ffff", 16'hAAAA);
        msg = 16'hAAAA; tick(); check("decrypt_aaaa", 16'hFFFF);
        msg = 16'h1234; key = 16'h0000; tick(); check("pass_through", 16'h1234);
        msg = 16'hABCD;
        #3 check("between_edges", 16'h1234);
        tick(); check("next_edge", 16'hABCD);
        key = 16'h00FF; tick(); check("key_only_change", 16'hAB32);
        tick(); check("held_inputs", 16'hAB32);
        msg = 16'h0F0F;
        #2 rst_n = 1'b0;
        #1 check("midstream_reset", 16'h0000);
        tick(); check("reset_discards", 16'h0000);
        rst_n = 1'b1;
        #2 check("release_again", 16'h0000);
        for (int i = 0; i < WORDS_PER_MSG; i++) begin
            msg = otp_word_t'($urandom);
            key = otp_word_t'($urandom);
            msgs.push_back(msg);
            keys.push_back(key);
            tick();
            ciph.push_back(out);
            check($sformatf("encrypt_w%0d", i), ref_otp(msgs[i], keys[i]));
        end
        for (int i = 0; i < WORDS_PER_MSG; i++) begin
            msg = ciph[i];
            key = keys[i];
            tick();
            check($sformatf("decrypt_w%0d", i), msgs[i]);
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
